// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_PREP,
    MDU_RUN,
    MDU_FIX,
    MDU_DONE
  } mdu_state_t;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;

  // Iteration counter width: one extra bit over log2 so WIDTH itself is representable.
  function automatic int mdu_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for MULT, restoring trial-subtract-shift for DIV.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   d,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // MULT: acc = {partial product, remaining multiplier bits}
  assign sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});

  // DIV: acc = {remainder, remaining dividend bits}; shifted remainder needs WIDTH+1 bits
  assign trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, d};

  always_comb begin
    acc_out = acc_in;
    if (op == MDU_OP_MULT) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {acc_in[2*WIDTH-2:WIDTH-1], acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers; fixed WIDTH+3 cycle latency.
// Define MDU_SIGNED_EN for two's-complement (MULT/DIV) instead of unsigned (MULTU/DIVU).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);

  mdu_state_t         state_reg, state_next;
  logic               op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, d_reg;
  logic [2*WIDTH-1:0] acc_reg, step_acc;
  logic [CNT_W-1:0]   cnt_reg;
  logic               div0_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic               last_step;

  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_reg),
    .acc_in (acc_reg),
    .d      (d_reg),
    .acc_out(step_acc)
  );

`ifdef MDU_SIGNED_EN
  logic neg_res_reg, neg_rem_reg;

  assign a_mag = a_reg[WIDTH-1] ? -a_reg : a_reg;
  assign b_mag = b_reg[WIDTH-1] ? -b_reg : b_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (state_reg == MDU_PREP) begin
      neg_res_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
      neg_rem_reg <= a_reg[WIDTH-1];
    end
  end

  // Remainder follows the dividend sign; MIN / -1 wraps naturally to MIN.
  always_comb begin
    hi_fix = acc_reg[2*WIDTH-1:WIDTH];
    lo_fix = acc_reg[WIDTH-1:0];
    if (op_reg == MDU_OP_MULT) begin
      if (neg_res_reg) {hi_fix, lo_fix} = -acc_reg;
    end else begin
      if (neg_res_reg) lo_fix = -acc_reg[WIDTH-1:0];
      if (neg_rem_reg) hi_fix = -acc_reg[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign a_mag  = a_reg;
  assign b_mag  = b_reg;
  assign hi_fix = acc_reg[2*WIDTH-1:WIDTH];
  assign lo_fix = acc_reg[WIDTH-1:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= MDU_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != MDU_IDLE);
    done       = 1'b0;
    div0       = 1'b0;
    case (state_reg)
      MDU_IDLE: begin
        if (start) begin
          if (op == MDU_OP_DIV && b == '0) state_next = MDU_DONE;
          else                             state_next = MDU_PREP;
        end
      end
      MDU_PREP: state_next = MDU_RUN;
      MDU_RUN:  if (last_step) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_DONE;
      MDU_DONE: begin
        done       = 1'b1;
        div0       = div0_reg;
        state_next = MDU_IDLE;
      end
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_reg   <= MDU_OP_MULT;
      a_reg    <= '0;
      b_reg    <= '0;
      d_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      div0_reg <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      case (state_reg)
        MDU_IDLE: begin
          if (start) begin
            if (op == MDU_OP_DIV && b == '0) begin
              div0_reg <= 1'b1;
            end else begin
              div0_reg <= 1'b0;
              op_reg   <= op;
              a_reg    <= a;
              b_reg    <= b;
            end
          end
        end
        MDU_PREP: begin
          // Multiplier / dividend starts in the low half of the accumulator.
          if (op_reg == MDU_OP_MULT) begin
            acc_reg <= {{WIDTH{1'b0}}, b_mag};
            d_reg   <= a_mag;
          end else begin
            acc_reg <= {{WIDTH{1'b0}}, a_mag};
            d_reg   <= b_mag;
          end
          cnt_reg <= '0;
        end
        MDU_RUN: begin
          acc_reg <= step_acc;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        MDU_FIX: begin
          hi_reg <= hi_fix;
          lo_reg <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        s32, o32, bz32, dn32, d032;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, o8, bz8, dn8, d08;
  logic [7:0]  a8, b8, hi8, lo8;

  int checks   = 0;
  int failures = 0;

`ifdef MDU_SIGNED_EN
  localparam logic [31:0] E_M3X5_HI = 32'hFFFFFFFF, E_M3X5_LO = 32'hFFFFFFF1;
  localparam logic [31:0] E_M7D2_HI = 32'hFFFFFFFF, E_M7D2_LO = 32'hFFFFFFFD;
  localparam logic [7:0]  E_MIN_HI  = 8'h00,        E_MIN_LO  = 8'h80;
  localparam logic [7:0]  E_FFSQ_HI = 8'h00,        E_FFSQ_LO = 8'h01;
`else
  localparam logic [31:0] E_M3X5_HI = 32'h00000004, E_M3X5_LO = 32'hFFFFFFF1;
  localparam logic [31:0] E_M7D2_HI = 32'h00000001, E_M7D2_LO = 32'h7FFFFFFC;
  localparam logic [7:0]  E_MIN_HI  = 8'h80,        E_MIN_LO  = 8'h00;
  localparam logic [7:0]  E_FFSQ_HI = 8'hFE,        E_FFSQ_LO = 8'h01;
`endif

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(s32), .op(o32), .a(a32), .b(b32),
    .busy(bz32), .done(dn32), .div0(d032), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(s8), .op(o8), .a(a8), .b(b8),
    .busy(bz8), .done(dn8), .div0(d08), .hi(hi8), .lo(lo8)
  );

  task automatic run32(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic busy1, output logic div0_seen);
    @(negedge clock);
    s32 = 1'b1; o32 = op; a32 = a; b32 = b;
    @(negedge clock);
    s32 = 1'b0; cyc = 1; busy1 = bz32;
    while (dn32 !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    div0_seen = d032;
    $display("txn w32 op=%0d a=%h b=%h cycle=%0d hi=%h lo=%h div0=%0b", op, a, b, cyc, hi32, lo32, div0_seen);
  endtask

  task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b,
                      output int cyc, output logic div0_seen);
    @(negedge clock);
    s8 = 1'b1; o8 = op; a8 = a; b8 = b;
    @(negedge clock);
    s8 = 1'b0; cyc = 1;
    while (dn8 !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    div0_seen = d08;
    $display("txn w8 op=%0d a=%h b=%h cycle=%0d hi=%h lo=%h div0=%0b", op, a, b, cyc, hi8, lo8, div0_seen);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s32 = 1'b0; o32 = 1'b0; a32 = '0; b32 = '0;
    s8 = 1'b0; o8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bz32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bz32); end
    checks++; if (dn32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dn32); end
    checks++; if (d032 !== 1'b0) begin failures++; $display("FAIL reset_div0 got=%b exp=0", d032); end
    checks++; if ({hi32, lo32} !== 64'h0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", hi32, lo32); end
    checks++; if ({hi8, lo8} !== 16'h0) begin failures++; $display("FAIL reset_hilo8 got=%h_%h exp=0", hi8, lo8); end
  endtask

  task automatic test_mult();
    int cyc; logic busy1, dz;
    run32(1'b0, 32'd7, 32'd6, cyc, busy1, dz);
    checks++; if (cyc !== 35) begin failures++; $display("FAIL mult_latency got=%0d exp=35", cyc); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL mult_busy_c1 got=%b exp=1", busy1); end
    checks++; if (lo32 !== 32'd42 || hi32 !== 32'd0) begin failures++; $display("FAIL mult_7x6 got=%h_%h exp=0_2a", hi32, lo32); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL mult_div0 got=%b exp=0", dz); end
    @(negedge clock);
    checks++; if (bz32 !== 1'b0 || dn32 !== 1'b0) begin failures++; $display("FAIL mult_after_done busy=%b done=%b exp=0/0", bz32, dn32); end
    checks++; if (lo32 !== 32'd42) begin failures++; $display("FAIL mult_hold got=%h exp=2a", lo32); end
  endtask

  task automatic test_signed();
    int cyc; logic busy1, dz;
    run32(1'b0, 32'hFFFFFFFD, 32'd5, cyc, busy1, dz);
    checks++; if (hi32 !== E_M3X5_HI || lo32 !== E_M3X5_LO) begin failures++; $display("FAIL mult_m3x5 got=%h_%h exp=%h_%h", hi32, lo32, E_M3X5_HI, E_M3X5_LO); end
    run32(1'b1, 32'hFFFFFFF9, 32'd2, cyc, busy1, dz);
    checks++; if (hi32 !== E_M7D2_HI || lo32 !== E_M7D2_LO) begin failures++; $display("FAIL div_m7d2 got=%h_%h exp=%h_%h", hi32, lo32, E_M7D2_HI, E_M7D2_LO); end
    checks++; if (cyc !== 35) begin failures++; $display("FAIL div_latency got=%0d exp=35", cyc); end
  endtask

  task automatic test_div();
    int cyc; logic busy1, dz;
    run32(1'b1, 32'd100, 32'd7, cyc, busy1, dz);
    checks++; if (lo32 !== 32'd14 || hi32 !== 32'd2) begin failures++; $display("FAIL div_100_7 got=%h_%h exp=2_e", hi32, lo32); end
    run32(1'b1, 32'd5, 32'd0, cyc, busy1, dz);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL div0_latency got=%0d exp=1", cyc); end
    checks++; if (dz !== 1'b1 || busy1 !== 1'b1) begin failures++; $display("FAIL div0_flags div0=%b busy=%b exp=1/1", dz, busy1); end
    checks++; if (lo32 !== 32'd14 || hi32 !== 32'd2) begin failures++; $display("FAIL div0_hilo_kept got=%h_%h exp=2_e", hi32, lo32); end
    @(negedge clock);
    checks++; if (bz32 !== 1'b0 || d032 !== 1'b0) begin failures++; $display("FAIL div0_after busy=%b div0=%b exp=0/0", bz32, d032); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clock);
    s32 = 1'b1; o32 = 1'b0; a32 = 32'd9; b32 = 32'd11;
    @(negedge clock);
    s32 = 1'b0; cyc = 1;
    while (dn32 !== 1'b1 && cyc < 100) begin
      if (cyc == 10) begin s32 = 1'b1; o32 = 1'b1; a32 = 32'd3; b32 = 32'd3; end
      else s32 = 1'b0;
      @(negedge clock);
      cyc++;
    end
    s32 = 1'b0;
    $display("txn w32 mult 9x11 with repulse cycle=%0d hi=%h lo=%h", cyc, hi32, lo32);
    checks++; if (cyc !== 35) begin failures++; $display("FAIL ignore_latency got=%0d exp=35", cyc); end
    checks++; if (lo32 !== 32'd99 || hi32 !== 32'd0) begin failures++; $display("FAIL ignore_result got=%h_%h exp=0_63", hi32, lo32); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic busy1, dz;
    run32(1'b0, 32'h00010000, 32'h00010000, cyc, busy1, dz);
    checks++; if (hi32 !== 32'd1 || lo32 !== 32'd0) begin failures++; $display("FAIL b2b_first got=%h_%h exp=1_0", hi32, lo32); end
    run32(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, cyc, busy1, dz);
    checks++; if (cyc !== 35) begin failures++; $display("FAIL b2b_latency got=%0d exp=35", cyc); end
    checks++; if (hi32 !== 32'h3FFFFFFF || lo32 !== 32'h00000001) begin failures++; $display("FAIL b2b_second got=%h_%h exp=3fffffff_1", hi32, lo32); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic seen;
    @(negedge clock);
    s32 = 1'b1; o32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clock);
    s32 = 1'b0; cyc = 1;
    while (cyc < 10) begin @(negedge clock); cyc++; end
    reset = 1'b1;
    #1;
    checks++; if (bz32 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bz32); end
    checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi32, lo32); end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clock);
      if (dn32 === 1'b1) seen = 1'b1;
    end
    $display("txn w32 div 1000/3 reset at cycle 10, done_seen=%0b", seen);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_w8();
    int cyc; logic dz;
    run8(1'b1, 8'h80, 8'hFF, cyc, dz);
    checks++; if (cyc !== 11) begin failures++; $display("FAIL w8_latency got=%0d exp=11", cyc); end
    checks++; if (hi8 !== E_MIN_HI || lo8 !== E_MIN_LO) begin failures++; $display("FAIL w8_min_div got=%h_%h exp=%h_%h", hi8, lo8, E_MIN_HI, E_MIN_LO); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL w8_div0 got=%b exp=0", dz); end
    run8(1'b0, 8'hFF, 8'hFF, cyc, dz);
    checks++; if (hi8 !== E_FFSQ_HI || lo8 !== E_FFSQ_LO) begin failures++; $display("FAIL w8_mult got=%h_%h exp=%h_%h", hi8, lo8, E_FFSQ_HI, E_FFSQ_LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_signed();
    test_div();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
